mac_tx_arbiter: RTL and testbench

- Frame-level arbiter sharing the single MAC TX byte interface between two frame sources.
- Port 0 is the IQ stream packetizer; port 1 is the control/ARP reply source.
- Grants whole frames (sop..eop), enforces an inter-frame idle gap, and forwards MAC backpressure to the granted source only.
- Sits between the packet sources and the MAC TX FIFO interface.

---
 rtl/mac_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter
//   Frame-level arbiter that shares one MAC TX byte interface between two
//   frame sources. Port 0 is the IQ stream packetizer and port 1 is the
//   control/ARP reply source. A grant covers a whole frame (sop..eop), and
//   an idle gap of IFG_CYCLES follows every frame. MAC backpressure reaches
//   only the granted source.
//
//   Parameters
//     PRIORITY     0 = round-robin, 1 = port 0 strict priority
//     IFG_CYCLES   idle cycles after each eop before the next grant (0..255)
//     WDOG_CYCLES  stall limit for the watchdog (1..65535)
//
//   Build option
//     MAC_TX_WATCHDOG_EN  when defined, a granted port that stalls for
//                         WDOG_CYCLES cycles has its frame closed with an
//                         errored eop. Without it, wdog_abort is tied 0.
//
//   Ports
//     clk, rst                 clock; asynchronous active-high reset
//     reqN/gntN/rdyN           per-port request, grant, write-ready
//     dataN/sopN/eopN/errN/wrenN  per-port byte stream
//     tx_data/sop/eop/err/wren byte stream to the MAC (1-cycle latency)
//     tx_rdy, tx_a_full        MAC ready / FIFO almost full
//     drop_err                 pulse: a non-granted port wrote a byte
//     wdog_abort               pulse: the watchdog closed a frame
module mac_tx_arbiter #(
    parameter int PRIORITY    = 0,
    parameter int IFG_CYCLES  = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    output logic       gnt0,
    output logic       rdy0,
    input  logic [7:0] data0,
    input  logic       sop0,
    input  logic       eop0,
    input  logic       err0,
    input  logic       wren0,
    input  logic       req1,
    output logic       gnt1,
    output logic       rdy1,
    input  logic [7:0] data1,
    input  logic       sop1,
    input  logic       eop1,
    input  logic       err1,
    input  logic       wren1,
    output logic [7:0] tx_data,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       tx_err,
    output logic       tx_wren,
    input  logic       tx_rdy,
    input  logic       tx_a_full,
    output logic       drop_err,
    output logic       wdog_abort
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

    state_t     state, state_nxt;
    logic       last1, last1_nxt;     // 1 = port 1 was served last
    logic [7:0] gap_cnt, gap_cnt_nxt;

    logic       g0, g1;
    logic       sel_wren, sel_sop, sel_eop, sel_err;
    logic [7:0] sel_data;
    logic       frame_end;
    logic       wd_hit;

    // Grants are a decode of the state register, so they rise the cycle
    // after the IDLE decision and fall the cycle after the closing eop.
    assign g0   = (state == GRANT0);
    assign g1   = (state == GRANT1);
    assign gnt0 = g0;
    assign gnt1 = g1;
    assign rdy0 = g0 & tx_rdy & ~tx_a_full;
    assign rdy1 = g1 & tx_rdy & ~tx_a_full;

    // Only the granted port's stream is considered; the other port's
    // wren never reaches the MAC.
    assign sel_wren  = (g0 & wren0) | (g1 & wren1);
    assign sel_data  = g1 ? data1 : data0;
    assign sel_sop   = g1 ? sop1  : sop0;
    assign sel_eop   = g1 ? eop1  : eop0;
    assign sel_err   = g1 ? err1  : err0;
    assign frame_end = sel_wren & sel_eop;

`ifdef MAC_TX_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // Fires on the cycle the stall count reaches WDOG_CYCLES; the forced
    // eop is registered onto tx_* at the same edge.
    assign wd_hit = (g0 | g1) & ~sel_wren & (wd_cnt == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (!(g0 | g1) || sel_wren || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    // Watchdog compiled out; WDOG_CYCLES is never negative, so this is 0.
    assign wd_hit = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last1   <= 1'b1;   // port 0 wins the first tie
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            last1   <= last1_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last1_nxt   = last1;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || (PRIORITY != 0) || last1))
                    state_nxt = GRANT0;
                else if (req1)
                    state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                // Request deassertion is ignored here: the grant holds
                // until eop (or a watchdog close).
                if (frame_end || wd_hit) begin
                    last1_nxt = (state == GRANT1);
                    if (IFG_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = 8'(IFG_CYCLES);
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - 8'd1;
                if (gap_cnt <= 8'd1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data    <= '0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            tx_err     <= 1'b0;
            tx_wren    <= 1'b0;
            drop_err   <= 1'b0;
            wdog_abort <= 1'b0;
        end else begin
            tx_wren    <= sel_wren | wd_hit;
            tx_sop     <= sel_wren & sel_sop;
            tx_eop     <= frame_end | wd_hit;
            tx_err     <= (sel_wren & sel_err) | wd_hit;
            drop_err   <= (wren0 & ~g0) | (wren1 & ~g1);
            wdog_abort <= wd_hit;
            // tx_data holds its last value while nothing is written.
            if (wd_hit)
                tx_data <= '0;
            else if (sel_wren)
                tx_data <= sel_data;
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for mac_tx_arbiter. Two instances share clock, reset and MAC
// status: u_rr (round-robin) and u_sp (port 0 strict priority). Bytes
// written by a source are pushed to a per-instance queue and popped when
// tx_wren appears.
module tb_mac_tx_arbiter;
    localparam int IFG  = 16;
    localparam int WDOG = 8;

    typedef struct packed {
        logic       req;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic       wren;
    } src_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } beat_t;

    typedef struct {
        logic tx_rdy;
        logic a_full;
        logic req1;
        logic exp_rdy0;
        logic exp_rdy1;
    } rdy_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_rdy = 1'b1;
    logic tx_a_full = 1'b0;
    src_t src[2][2];
    logic gnt[2][2];
    logic rdy[2][2];
    logic [7:0] tx_data[2];
    logic tx_sop[2], tx_eop[2], tx_err[2], tx_wren[2];
    logic drop_err[2], wdog_abort[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t sb0[$];
    beat_t sb1[$];
    int    gorder0[$];
    int    gorder1[$];
    int    last_eop[2];
    bit    eop_seen[2];
    bit    gap_chk[2];
    logic  prev_gnt[2];
    int    drops[2];
    int    aborts[2];
    int    abort_cyc;
    beat_t mon_got, mon_want;
    logic  mon_g;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_tx_arbiter #(.PRIORITY(0), .IFG_CYCLES(IFG), .WDOG_CYCLES(WDOG)) u_rr (
        .clk(clk), .rst(rst),
        .req0(src[0][0].req), .gnt0(gnt[0][0]), .rdy0(rdy[0][0]),
        .data0(src[0][0].data), .sop0(src[0][0].sop), .eop0(src[0][0].eop),
        .err0(src[0][0].err), .wren0(src[0][0].wren),
        .req1(src[0][1].req), .gnt1(gnt[0][1]), .rdy1(rdy[0][1]),
        .data1(src[0][1].data), .sop1(src[0][1].sop), .eop1(src[0][1].eop),
        .err1(src[0][1].err), .wren1(src[0][1].wren),
        .tx_data(tx_data[0]), .tx_sop(tx_sop[0]), .tx_eop(tx_eop[0]),
        .tx_err(tx_err[0]), .tx_wren(tx_wren[0]),
        .tx_rdy(tx_rdy), .tx_a_full(tx_a_full),
        .drop_err(drop_err[0]), .wdog_abort(wdog_abort[0]));

    mac_tx_arbiter #(.PRIORITY(1), .IFG_CYCLES(IFG), .WDOG_CYCLES(WDOG)) u_sp (
        .clk(clk), .rst(rst),
        .req0(src[1][0].req), .gnt0(gnt[1][0]), .rdy0(rdy[1][0]),
        .data0(src[1][0].data), .sop0(src[1][0].sop), .eop0(src[1][0].eop),
        .err0(src[1][0].err), .wren0(src[1][0].wren),
        .req1(src[1][1].req), .gnt1(gnt[1][1]), .rdy1(rdy[1][1]),
        .data1(src[1][1].data), .sop1(src[1][1].sop), .eop1(src[1][1].eop),
        .err1(src[1][1].err), .wren1(src[1][1].wren),
        .tx_data(tx_data[1]), .tx_sop(tx_sop[1]), .tx_eop(tx_eop[1]),
        .tx_err(tx_err[1]), .tx_wren(tx_wren[1]),
        .tx_rdy(tx_rdy), .tx_a_full(tx_a_full),
        .drop_err(drop_err[1]), .wdog_abort(wdog_abort[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input beat_t b);
        if (d == 0) sb0.push_back(b);
        else        sb1.push_back(b);
    endtask

    // Main-thread alignment: inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source model: call at posedge+2; requests, waits for grant, then
    // writes len bytes honouring rdy. req is left high for the caller.
    task automatic send_frame(input int d, input int p, input int len, input logic [7:0] base);
        int n = 0;
        int i = 0;
        src[d][p].req = 1'b1;
        while (!gnt[d][p]) begin
            @(posedge clk); #2;
            n++;
            if (n > 2000) begin
                checks++; errors++;
                $display("FAIL grant_timeout dut%0d port%0d: got no grant want gnt", d, p);
                return;
            end
        end
        n = 0;
        while (i < len) begin
            if (rdy[d][p]) begin
                src[d][p].data = base + 8'(i);
                src[d][p].sop  = (i == 0);
                src[d][p].eop  = (i == len - 1);
                src[d][p].err  = 1'b0;
                src[d][p].wren = 1'b1;
                push(d, {src[d][p].data, src[d][p].sop, src[d][p].eop, 1'b0});
                i++;
            end else begin
                src[d][p].wren = 1'b0;
            end
            @(posedge clk); #2;
            n++;
            if (n > 2000) begin
                checks++; errors++;
                $display("FAIL frame_timeout dut%0d port%0d: got %0d bytes want %0d", d, p, i, len);
                break;
            end
        end
        src[d][p].wren = 1'b0;
        src[d][p].sop  = 1'b0;
        src[d][p].eop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                src[d][p] = '0;
        tx_rdy = 1'b1;
        tx_a_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb0.delete(); sb1.delete();
        gorder0.delete(); gorder1.delete();
        eop_seen = '{0, 0};
        gap_chk  = '{0, 0};
        drops    = '{0, 0};
    endtask

    // Output monitor: scoreboard, grant order and inter-frame gap.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_wren[d]) begin
                mon_got = {tx_data[d], tx_sop[d], tx_eop[d], tx_err[d]};
                if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected dut%0d: got %0h want no byte", d, mon_got);
                end else begin
                    if (d == 0) mon_want = sb0.pop_front();
                    else        mon_want = sb1.pop_front();
                    chk($sformatf("tx_beat dut%0d", d), 32'(mon_got), 32'(mon_want));
                end
                if (tx_eop[d]) begin
                    last_eop[d] = cyc;
                    eop_seen[d] = 1'b1;
                end
            end
            mon_g = gnt[d][0] | gnt[d][1];
            if (mon_g && !prev_gnt[d]) begin
                if (d == 0) gorder0.push_back(gnt[d][1] ? 1 : 0);
                else        gorder1.push_back(gnt[d][1] ? 1 : 0);
                // Idle cycles strictly between the MAC's eop and the new grant.
                if (gap_chk[d] && eop_seen[d])
                    chk($sformatf("ifg dut%0d", d), 32'(cyc - last_eop[d] - 1), 32'(IFG));
            end
            prev_gnt[d] = mon_g;
            if (drop_err[d]) drops[d]++;
            if (wdog_abort[d]) begin
                aborts[d]++;
                if (d == 0) abort_cyc = cyc;
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL global_timeout: got no finish want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rdy_vec_t rv[6];
        int exp_rr[6];
        int exp_sp[6];
        int n;
        int lc;

        rv[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_rr = '{0, 1, 0, 1, 0, 1};
        exp_sp = '{0, 0, 0, 1, 1, 1};
        aborts = '{0, 0};
        prev_gnt = '{0, 0};
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                src[d][p] = '0;

        // Reset values.
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_outs dut%0d", d),
                {20'd0, tx_data[d], gnt[d][0], gnt[d][1], rdy[d][0], rdy[d][1]},
                32'd0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_flags dut%0d", d),
                {26'd0, tx_sop[d], tx_eop[d], tx_err[d], tx_wren[d], drop_err[d], wdog_abort[d]},
                32'd0);

        // 60-byte frame on port 0, grant latency, then a short frame to
        // measure the gap.
        do_reset();
        gap_chk[0] = 1'b1;
        src[0][0].req = 1'b1;
        @(negedge clk);
        chk("gnt0_same_cycle", gnt[0][0], 0);
        @(negedge clk);
        chk("gnt0_latency", gnt[0][0], 1);
        @(posedge clk); #2;
        send_frame(0, 0, 60, 8'h10);
        chk("gnt0_drop_after_eop", gnt[0][0], 0);
        send_frame(0, 0, 4, 8'h80);
        src[0][0].req = 1'b0;
        repeat (3) tick();
        chk("sb_empty_single", sb0.size(), 0);

        // Both ports pending, 3 frames each, on both arbitration modes.
        do_reset();
        gap_chk = '{1, 1};
        fork
            begin #1; repeat (3) send_frame(0, 0, 8, 8'h20); src[0][0].req = 1'b0; end
            begin #1; repeat (3) send_frame(0, 1, 6, 8'h40); src[0][1].req = 1'b0; end
            begin #1; repeat (3) send_frame(1, 0, 8, 8'h60); src[1][0].req = 1'b0; end
            begin #1; repeat (3) send_frame(1, 1, 6, 8'hA0); src[1][1].req = 1'b0; end
        join
        repeat (3) tick();
        chk("rr_grants", gorder0.size(), 6);
        chk("sp_grants", gorder1.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_order[%0d]", i), (i < gorder0.size()) ? gorder0[i] : 99, exp_rr[i]);
            chk($sformatf("sp_order[%0d]", i), (i < gorder1.size()) ? gorder1[i] : 99, exp_sp[i]);
        end
        chk("sb_empty_rr", sb0.size(), 0);
        chk("sb_empty_sp", sb1.size(), 0);

        // rdy qualification while port 0 holds the grant.
        do_reset();
        src[0][0].req = 1'b1;
        n = 0;
        while (!gnt[0][0] && n < 10) begin tick(); n++; end
        chk("tbl_gnt0", gnt[0][0], 1);
        for (int i = 0; i < 6; i++) begin
            tx_rdy = rv[i].tx_rdy;
            tx_a_full = rv[i].a_full;
            src[0][1].req = rv[i].req1;
            @(negedge clk);
            chk($sformatf("tbl_rdy[%0d]", i), {rdy[0][0], rdy[0][1]}, {rv[i].exp_rdy0, rv[i].exp_rdy1});
            tick();
        end
        tx_rdy = 1'b1; tx_a_full = 1'b0; src[0][1].req = 1'b0;
        #1;
        send_frame(0, 0, 1, 8'hC0);
        src[0][0].req = 1'b0;
        repeat (3) tick();
        chk("sb_empty_tbl", sb0.size(), 0);

        // Port 1 writes while port 0 owns the MAC.
        do_reset();
        fork
            begin #1; send_frame(0, 0, 20, 8'h30); src[0][0].req = 1'b0; end
            begin
                repeat (6) @(posedge clk);
                #2;
                for (int i = 0; i < 3; i++) begin
                    src[0][1].data = 8'hEE;
                    src[0][1].sop  = (i == 0);
                    src[0][1].wren = 1'b1;
                    @(posedge clk); #2;
                end
                src[0][1].wren = 1'b0;
                src[0][1].sop  = 1'b0;
            end
        join
        repeat (3) tick();
        chk("drop_err_pulses", drops[0], 3);
        chk("sb_empty_drop", sb0.size(), 0);

        // MAC almost-full for 10 cycles mid-frame.
        do_reset();
        fork
            begin #1; send_frame(0, 0, 30, 8'h50); src[0][0].req = 1'b0; end
            begin
                repeat (12) @(posedge clk);
                #1;
                tx_a_full = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("rdy0_a_full", rdy[0][0], 0);
                    tick();
                end
                tx_a_full = 1'b0;
            end
        join
        repeat (3) tick();
        chk("sb_empty_afull", sb0.size(), 0);

        // Reset mid-frame: port 0 was served last, so only reset restores
        // port 0 as the tie winner.
        src[0][0].req = 1'b1;
        n = 0;
        while (!gnt[0][0] && n < 50) begin tick(); n++; end
        chk("rstmid_gnt0", gnt[0][0], 1);
        #1;
        for (int i = 0; i < 3; i++) begin
            src[0][0].data = 8'hD0 + 8'(i);
            src[0][0].sop  = (i == 0);
            src[0][0].wren = 1'b1;
            push(0, {src[0][0].data, src[0][0].sop, 1'b0, 1'b0});
            @(posedge clk); #2;
        end
        #1;
        rst = 1'b1;
        src[0][0] = '0;
        #1;
        chk("rstmid_tx_wren", tx_wren[0], 0);
        chk("rstmid_gnt0_low", gnt[0][0], 0);
        sb0.delete();
        tick();
        rst = 1'b0;
        eop_seen = '{0, 0};
        src[0][0].req = 1'b1;
        src[0][1].req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_first_tie", {gnt[0][0], gnt[0][1]}, 2'b10);

`ifdef MAC_TX_WATCHDOG_EN
        // Port 0 stalls after sop plus 5 bytes; port 1 is waiting.
        do_reset();
        gap_chk[0] = 1'b1;
        aborts = '{0, 0};
        src[0][0].req = 1'b1;
        src[0][1].req = 1'b1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!gnt[0][0] && n < 10);
        chk("wd_gnt0", gnt[0][0], 1);
        lc = 0;
        for (int i = 0; i < 6; i++) begin
            src[0][0].data = 8'hB0 + 8'(i);
            src[0][0].sop  = (i == 0);
            src[0][0].wren = 1'b1;
            push(0, {src[0][0].data, src[0][0].sop, 1'b0, 1'b0});
            lc = cyc;
            @(posedge clk); #2;
        end
        src[0][0].wren = 1'b0;
        src[0][0].sop  = 1'b0;
        push(0, {8'h00, 1'b0, 1'b1, 1'b1});
        n = 0;
        while (aborts[0] == 0 && n < 40) begin @(negedge clk); n++; end
        chk("wd_abort_latency", 32'(abort_cyc - lc), 32'd9);
        @(posedge clk); #2;
        src[0][0].data = 8'h77;
        src[0][0].wren = 1'b1;
        @(posedge clk); #2;
        src[0][0].wren = 1'b0;
        src[0][0].req  = 1'b0;
        send_frame(0, 1, 4, 8'h90);
        src[0][1].req = 1'b0;
        repeat (3) tick();
        chk("wd_abort_pulses", aborts[0], 1);
        chk("wd_late_drop", drops[0], 1);
        chk("wd_grants", gorder0.size(), 2);
        chk("wd_order", (gorder0.size() > 1) ? gorder0[1] : 99, 1);
        chk("sb_empty_wd", sb0.size(), 0);
`else
        chk("wdog_tied_low", aborts[0] + aborts[1], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
